flow_sequencer: RTL and testbench

- Unified control-flow sequencer for the 5-stage pipeline. It replaces the separate call/ret/interrupt/rti micro-sequencers.
- It takes requests from decode (CALL, RET, RTI) and from the external interrupt line, and arbitrates between them.
- It injects fixed micro-instruction sequences into the fetch→decode path, stalls fetch, and drives the PC-load path.
- Sits beside fetch. Its outputs feed the instruction-inject mux, the PC-increment enable and the PC-source mux.

---
 rtl/flow_pkg.sv | 57 +++++
 rtl/flow_arbiter.sv | 62 ++++++
 rtl/flow_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_flow_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared types and micro-op encodings for the control-flow sequencer.
package flow_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PUSH_HI  = 4'd1,
    ST_PUSH_LO  = 4'd2,
    ST_PUSH_CCR = 4'd3,
    ST_POP_CCR  = 4'd4,
    ST_POP_LO   = 4'd5,
    ST_POP_HI   = 4'd6,
    ST_DRAIN    = 4'd7,
    ST_LOAD     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    KIND_CALL = 2'd0,
    KIND_RET  = 2'd1,
    KIND_INT  = 2'd2,
    KIND_RTI  = 2'd3
  } kind_t;

  localparam logic [15:0] UOP_NOP        = 16'h0000;
  localparam logic [15:0] UOP_PUSH_PC_HI = 16'hF801;
  localparam logic [15:0] UOP_PUSH_PC_LO = 16'hF802;
  localparam logic [15:0] UOP_PUSH_CCR   = 16'hF803;
  localparam logic [15:0] UOP_POP_CCR    = 16'hF804;
  localparam logic [15:0] UOP_POP_PC_LO  = 16'hF805;
  localparam logic [15:0] UOP_POP_PC_HI  = 16'hF806;

  // Micro-instruction injected while sitting in a given state.
  function automatic logic [15:0] uop_for_state(input state_t st);
    logic [15:0] uop;
    case (st)
      ST_PUSH_HI:  uop = UOP_PUSH_PC_HI;
      ST_PUSH_LO:  uop = UOP_PUSH_PC_LO;
      ST_PUSH_CCR: uop = UOP_PUSH_CCR;
      ST_POP_CCR:  uop = UOP_POP_CCR;
      ST_POP_LO:   uop = UOP_POP_PC_LO;
      ST_POP_HI:   uop = UOP_POP_PC_HI;
      default:     uop = UOP_NOP;
    endcase
    return uop;
  endfunction

  // True for the states that replace the fetched instruction.
  function automatic logic is_inject_state(input state_t st);
    logic r;
    case (st)
      ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_CCR,
      ST_POP_CCR, ST_POP_LO, ST_POP_HI: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flow_arbiter.sv
// Fixed-priority request selection plus the interrupt rising-edge latch.
module flow_arbiter
  import flow_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rti_req,
  input  logic       ret_req,
  input  logic       call_req,
  input  logic       int_req,
  input  logic       in_service,
  input  logic       int_clear,
  output logic       grant,
  output logic [1:0] grant_kind,
  output logic       int_pending
);

  logic int_req_q_r;
  logic int_pending_r;

  // Edge-detect int_req; a rise is latched only while no ISR is active.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_req_q_r   <= 1'b0;
      int_pending_r <= 1'b0;
    end else begin
      int_req_q_r <= int_req;
      if (int_clear) begin
        int_pending_r <= 1'b0;
      end else if (int_req && !int_req_q_r && !in_service) begin
        int_pending_r <= 1'b1;
      end else begin
        int_pending_r <= int_pending_r;
      end
    end
  end

  // Decoded requests beat the interrupt: their instructions are already in the pipe.
  always_comb begin
    grant      = 1'b0;
    grant_kind = KIND_CALL;
    if (rti_req) begin
      grant      = 1'b1;
      grant_kind = KIND_RTI;
    end else if (ret_req) begin
      grant      = 1'b1;
      grant_kind = KIND_RET;
    end else if (call_req) begin
      grant      = 1'b1;
      grant_kind = KIND_CALL;
    end else if (int_pending_r) begin
      grant      = 1'b1;
      grant_kind = KIND_INT;
    end else begin
      grant      = 1'b0;
      grant_kind = KIND_CALL;
    end
  end

  assign int_pending = int_pending_r;

endmodule

// File: rtl/flow_sequencer.sv
// Unified CALL/RET/INT/RTI sequencer: injects push/pop micro-ops, stalls
// fetch and drives the PC-load path. Outputs are registered from next state.
module flow_sequencer
  import flow_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic        rti_req,
  input  logic [15:0] call_target,
  input  logic        int_req,
  output logic        stall,
  output logic        inject_valid,
  output logic [15:0] inject_instr,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        int_ack,
  output logic        in_service,
  output logic        busy
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state_r, state_next_s;
  kind_t       kind_r, kind_next_s;
  logic [2:0]  drain_cnt_r, drain_next_s;
  logic [15:0] target_r, target_next_s;
  logic        in_service_r, in_service_next_s;
  logic        int_clear_s;

  logic        grant_s;
  logic [1:0]  grant_kind_s;
  logic        int_pending_s;

  logic        stall_r, inject_valid_r, pc_load_r, int_ack_r;
  logic [15:0] inject_instr_r;
  logic [31:0] pc_next_r;

  logic        stall_next_s, inject_valid_next_s, pc_load_next_s, int_ack_next_s;
  logic [15:0] inject_instr_next_s;
  logic [31:0] pc_next_next_s;

  flow_arbiter u_arbiter (
    .clk         (clk),
    .reset       (reset),
    .rti_req     (rti_req),
    .ret_req     (ret_req),
    .call_req    (call_req),
    .int_req     (int_req),
    .in_service  (in_service_r),
    .int_clear   (int_clear_s),
    .grant       (grant_s),
    .grant_kind  (grant_kind_s),
    .int_pending (int_pending_s)
  );

  // Next-state, drain counter, captured target and ISR flag.
  always_comb begin
    state_next_s      = state_r;
    kind_next_s       = kind_r;
    drain_next_s      = drain_cnt_r;
    target_next_s     = target_r;
    in_service_next_s = in_service_r;
    int_clear_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          kind_next_s = kind_t'(grant_kind_s);
          case (kind_t'(grant_kind_s))
            KIND_CALL: begin
              state_next_s  = ST_PUSH_HI;
              target_next_s = call_target;
            end
            KIND_INT: state_next_s = ST_PUSH_HI;
            KIND_RET: state_next_s = ST_POP_LO;
            KIND_RTI: state_next_s = ST_POP_CCR;
            default:  state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PUSH_HI: state_next_s = ST_PUSH_LO;
      ST_PUSH_LO: begin
        if (kind_r == KIND_INT) begin
          state_next_s = ST_PUSH_CCR;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_PUSH_CCR: begin
        // Only the interrupt sequence pushes CCR; entering LOAD ends the pending request.
        state_next_s      = ST_LOAD;
        int_clear_s       = 1'b1;
        in_service_next_s = 1'b1;
      end
      ST_POP_CCR: state_next_s = ST_POP_LO;
      ST_POP_LO:  state_next_s = ST_POP_HI;
      ST_POP_HI: begin
        state_next_s = ST_DRAIN;
        drain_next_s = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        if (drain_cnt_r == 3'd0) begin
          state_next_s = ST_IDLE;
          if (kind_r == KIND_RTI) begin
            in_service_next_s = 1'b0;
          end else begin
            in_service_next_s = in_service_r;
          end
        end else begin
          drain_next_s = drain_cnt_r - 3'd1;
        end
      end
      ST_LOAD: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output values decoded from the state being entered, so they register with it.
  always_comb begin
    stall_next_s        = (state_next_s != ST_IDLE);
    inject_valid_next_s = is_inject_state(state_next_s);
    inject_instr_next_s = uop_for_state(state_next_s);
    pc_load_next_s      = (state_next_s == ST_LOAD);
    int_ack_next_s      = 1'b0;
    pc_next_next_s      = 32'h0000_0000;
    if (state_next_s == ST_LOAD) begin
      if (kind_next_s == KIND_INT) begin
        pc_next_next_s = INT_VECTOR;
        int_ack_next_s = 1'b1;
      end else begin
        pc_next_next_s = {16'h0000, target_next_s};
        int_ack_next_s = 1'b0;
      end
    end else begin
      pc_next_next_s = 32'h0000_0000;
    end
  end

  // State, sequencing registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      kind_r         <= KIND_CALL;
      drain_cnt_r    <= 3'd0;
      target_r       <= 16'h0000;
      in_service_r   <= 1'b0;
      stall_r        <= 1'b0;
      inject_valid_r <= 1'b0;
      inject_instr_r <= UOP_NOP;
      pc_load_r      <= 1'b0;
      pc_next_r      <= 32'h0000_0000;
      int_ack_r      <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      kind_r         <= kind_next_s;
      drain_cnt_r    <= drain_next_s;
      target_r       <= target_next_s;
      in_service_r   <= in_service_next_s;
      stall_r        <= stall_next_s;
      inject_valid_r <= inject_valid_next_s;
      inject_instr_r <= inject_instr_next_s;
      pc_load_r      <= pc_load_next_s;
      pc_next_r      <= pc_next_next_s;
      int_ack_r      <= int_ack_next_s;
    end
  end

  assign stall        = stall_r;
  assign busy         = stall_r;
  assign inject_valid = inject_valid_r;
  assign inject_instr = inject_instr_r;
  assign pc_load      = pc_load_r;
  assign pc_next      = pc_next_r;
  assign int_ack      = int_ack_r;
  assign in_service   = in_service_r;

endmodule

// File: tb/tb_flow_sequencer.sv
// Directed self-checking bench for flow_sequencer.
module tb_flow_sequencer;

  logic        clk;
  logic        reset;
  logic        call_req, ret_req, rti_req, int_req;
  logic [15:0] call_target;
  logic        stall, inject_valid, pc_load, int_ack, in_service, busy;
  logic [15:0] inject_instr;
  logic [31:0] pc_next;

  int n_checks;
  int n_fail;
  int ack_seen;

  flow_sequencer #(
    .DRAIN_CYCLES (3),
    .INT_VECTOR   (32'h0000_0020)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_req     (call_req),
    .ret_req      (ret_req),
    .rti_req      (rti_req),
    .call_target  (call_target),
    .int_req      (int_req),
    .stall        (stall),
    .inject_valid (inject_valid),
    .inject_instr (inject_instr),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .int_ack      (int_ack),
    .in_service   (in_service),
    .busy         (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoded requests must never arrive while the sequencer is busy.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      assert (!(busy && (call_req || ret_req || rti_req)))
      else begin
        n_fail++;
        $error("FAIL req_while_busy: observed busy=%0b call=%0b ret=%0b rti=%0b expected no request",
               busy, call_req, ret_req, rti_req);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (int_ack === 1'b1) ack_seen++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic st, input logic iv,
                         input logic [15:0] ins, input logic pl, input logic [31:0] pn,
                         input logic ack, input logic svc, input logic bz);
    chk({tag, ".stall"},        {31'd0, stall},        {31'd0, st});
    chk({tag, ".inject_valid"}, {31'd0, inject_valid}, {31'd0, iv});
    chk({tag, ".inject_instr"}, {16'd0, inject_instr}, {16'd0, ins});
    chk({tag, ".pc_load"},      {31'd0, pc_load},      {31'd0, pl});
    chk({tag, ".pc_next"},      pc_next,               pn);
    chk({tag, ".int_ack"},      {31'd0, int_ack},      {31'd0, ack});
    chk({tag, ".in_service"},   {31'd0, in_service},   {31'd0, svc});
    chk({tag, ".busy"},         {31'd0, busy},         {31'd0, bz});
  endtask

  initial begin
    n_checks = 0; n_fail = 0; ack_seen = 0;
    reset = 1'b1; call_req = 1'b0; ret_req = 1'b0; rti_req = 1'b0;
    int_req = 1'b0; call_target = 16'h0000;

    // Power-on reset.
    tick(); tick();
    chk_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_out("idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles in the middle of a CALL.
    call_req = 1'b1; call_target = 16'h0456;
    tick();
    call_req = 1'b0;
    chk_out("abort.push_hi", 1'b1, 1'b1, 16'hF801, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("abort.push_lo", 1'b1, 1'b1, 16'hF802, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_out("abort.reset", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("abort.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // CALL to 0x0123.
    call_req = 1'b1; call_target = 16'h0123;
    tick();
    call_req = 1'b0; call_target = 16'hFFFF;
    chk_out("call.t1", 1'b1, 1'b1, 16'hF801, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("call.t2", 1'b1, 1'b1, 16'hF802, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("call.t3", 1'b1, 1'b0, 16'h0000, 1'b1, 32'h0000_0123, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("call.t4", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // RET with a three-cycle drain.
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    chk_out("ret.pop_lo", 1'b1, 1'b1, 16'hF805, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("ret.pop_hi", 1'b1, 1'b1, 16'hF806, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("ret.drain%0d", i), 1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk_out("ret.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Interrupt entry: edge latched first, sequence starts the next cycle.
    int_req = 1'b1;
    tick();
    chk_out("int.latch", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("int.push_hi", 1'b1, 1'b1, 16'hF801, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("int.push_lo", 1'b1, 1'b1, 16'hF802, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("int.push_ccr", 1'b1, 1'b1, 16'hF803, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("int.load", 1'b1, 1'b0, 16'h0000, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("int.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // A new edge while in service is ignored.
    int_req = 1'b0;
    tick();
    int_req = 1'b1;
    tick();
    tick();
    chk_out("masked.a", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    int_req = 1'b0;
    tick();
    chk_out("masked.b", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // RTI pops CCR, PC and clears in_service on drain exit.
    rti_req = 1'b1;
    tick();
    rti_req = 1'b0;
    chk_out("rti.pop_ccr", 1'b1, 1'b1, 16'hF804, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("rti.pop_lo", 1'b1, 1'b1, 16'hF805, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("rti.pop_hi", 1'b1, 1'b1, 16'hF806, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rti.drain%0d", i), 1'b1, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    end
    tick();
    chk_out("rti.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // A fresh interrupt is accepted again.
    int_req = 1'b1;
    tick();
    chk_out("int2.latch", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("int2.push_hi", 1'b1, 1'b1, 16'hF801, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk_out("int2.load", 1'b1, 1'b0, 16'h0000, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b1);
    int_req = 1'b0;
    tick();
    rti_req = 1'b1;
    tick();
    rti_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_out("rti2.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // CALL and interrupt edge together: CALL first, then INT.
    ack_seen = 0;
    call_req = 1'b1; call_target = 16'h0ABC; int_req = 1'b1;
    tick();
    call_req = 1'b0; call_target = 16'h0000;
    chk_out("both.call_hi", 1'b1, 1'b1, 16'hF801, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("both.call_lo", 1'b1, 1'b1, 16'hF802, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("both.call_load", 1'b1, 1'b0, 16'h0000, 1'b1, 32'h0000_0ABC, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("both.idle", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("both.int_hi", 1'b1, 1'b1, 16'hF801, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("both.int_lo", 1'b1, 1'b1, 16'hF802, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("both.int_ccr", 1'b1, 1'b1, 16'hF803, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("both.int_load", 1'b1, 1'b0, 16'h0000, 1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("both.end", 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    chk("both.ack_count", ack_seen, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
